// File: rtl/div_unit_pkg.sv
// Shared ALU op codes and the divider's state encoding.
// The ALU codes match the ones the decoder uses for DIV/DIVU.
package div_unit_pkg;

  localparam logic [5:0] ALU_ADD          = 6'b100000;
  localparam logic [5:0] ALU_SIGNED_DIV   = 6'b011010;
  localparam logic [5:0] ALU_UNSIGNED_DIV = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {rem,quot} left, subtract divisor when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nx,
  output logic [WIDTH-1:0] quot_nx
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {rem, quot[WIDTH-1]};
  // rem < divisor on entry, so WIDTH+1 bits hold both the shifted value and the sign of the trial
  assign trial   = shifted - {1'b0, divisor};

  always_comb begin
    rem_nx  = shifted[WIDTH-1:0];
    quot_nx = {quot[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_nx  = trial[WIDTH-1:0];
      quot_nx = {quot[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative DIV/DIVU unit: restoring division on magnitudes, sign fix-up on the final load.
// Optional DIV_EARLY_OUT_EN: skip iteration when divisor is zero or |dividend| < |divisor|.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [5:0]       alu_controlE,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] src_aE,
  input  logic [WIDTH-1:0] src_bE,
  output logic             div_stallE,
  output logic             result_valid,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quot, divisor;
  logic [WIDTH-1:0] rem_nx, quot_nx;
  logic             sign_q, sign_r, dz;
  logic             is_signed, is_div, acc, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  function automatic logic [WIDTH-1:0] fix(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? -v : v;
  endfunction

  assign is_signed  = (alu_controlE == ALU_SIGNED_DIV);
  assign is_div     = is_signed || (alu_controlE == ALU_UNSIGNED_DIV);
  assign acc        = resetn && start && !flush && (state == IDLE) && is_div;
  assign a_neg      = is_signed && src_aE[WIDTH-1];
  assign b_neg      = is_signed && src_bE[WIDTH-1];
  assign a_mag      = fix(a_neg, src_aE);
  assign b_mag      = fix(b_neg, src_bE);
  assign div_stallE = acc || (state == DIV);

`ifdef DIV_EARLY_OUT_EN
  logic early;
  assign early = (src_bE == '0) || (a_mag < b_mag);
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .quot    (quot),
    .divisor (divisor),
    .rem_nx  (rem_nx),
    .quot_nx (quot_nx)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      cnt          <= '0;
      result_valid <= 1'b0;
      hi_out       <= '0;
      lo_out       <= '0;
      rem          <= '0;
      quot         <= '0;
      divisor      <= '0;
      sign_q       <= 1'b0;
      sign_r       <= 1'b0;
      dz           <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (flush) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: if (acc) begin
            rem     <= '0;
            quot    <= a_mag;
            divisor <= b_mag;
            sign_q  <= a_neg ^ b_neg;
            sign_r  <= a_neg;
            dz      <= (src_bE == '0);
            cnt     <= '0;
            state   <= DIV;
`ifdef DIV_EARLY_OUT_EN
            if (early) begin
              // quotient is 0 and the sign-corrected remainder is the dividend itself
              state        <= DONE;
              result_valid <= 1'b1;
              lo_out       <= (src_bE == '0) ? '1 : '0;
              hi_out       <= src_aE;
            end
`endif
          end
          DIV: begin
            rem  <= rem_nx;
            quot <= quot_nx;
            cnt  <= cnt + 1'b1;
            if (cnt == LAST) begin
              state        <= DONE;
              result_valid <= 1'b1;
              // a zero divisor yields all-ones quotient; remainder fix-up restores the raw dividend
              lo_out       <= dz ? '1 : fix(sign_q, quot_nx);
              hi_out       <= fix(sign_r, rem_nx);
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: cycle-level model of accept/latency/flush plus literal result checks.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [5:0]  ctrl = ALU_ADD;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] a_in = '0, b_in = '0;
  logic        stall, valid;
  logic [31:0] hi, lo;

  div_unit dut (
    .clk          (clk),
    .resetn       (resetn),
    .alu_controlE (ctrl),
    .start        (start),
    .flush        (flush),
    .src_aE       (a_in),
    .src_bE       (b_in),
    .div_stallE   (stall),
    .result_valid (valid),
    .hi_out       (hi),
    .lo_out       (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference division from the architectural rules
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 0) begin
      q = '1; r = a;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000; r = 0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b; r = a % b;
    end
    return {r, q};
  endfunction

  function automatic int latency(input logic sgn, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    logic [31:0] am, bm;
    am = (sgn && a[31]) ? -a : a;
    bm = (sgn && b[31]) ? -b : b;
    if (b == 0 || am < bm) return 1;
`endif
    return 33;
  endfunction

  // Model state: cycle of accept, cycle the result shows, last busy cycle
  int acc_cyc = -100, vld_cyc = -100, busy_end = -100;
  logic [31:0] pend_hi = '0, pend_lo = '0, exp_hi = '0, exp_lo = '0;
  int nvalid = 0, last_vld = -100;

  always @(negedge clk) begin
    logic is_div, acc_m, in_div, exp_stall, exp_valid;
    logic [63:0] rr;
    if (!resetn) begin
      acc_cyc = -100; vld_cyc = -100; busy_end = -100;
      exp_hi = '0; exp_lo = '0;
      chk("rst_stall", {31'b0, stall}, 32'd0);
      chk("rst_valid", {31'b0, valid}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
    end else begin
      is_div    = (ctrl == ALU_SIGNED_DIV) || (ctrl == ALU_UNSIGNED_DIV);
      acc_m     = start && !flush && (cyc > busy_end) && is_div;
      in_div    = (cyc > acc_cyc) && (cyc < vld_cyc);
      exp_stall = acc_m || in_div;
      exp_valid = (cyc == vld_cyc);
      if (exp_valid) begin exp_hi = pend_hi; exp_lo = pend_lo; end
      chk("stall", {31'b0, stall}, {31'b0, exp_stall});
      chk("valid", {31'b0, valid}, {31'b0, exp_valid});
      chk("hi", hi, exp_hi);
      chk("lo", lo, exp_lo);
      if (valid) begin nvalid++; last_vld = cyc; end
      if (flush) begin
        if (cyc < vld_cyc) vld_cyc = -100;
        if (busy_end > cyc) busy_end = cyc;
      end
      if (acc_m) begin
        rr       = ref_div(ctrl == ALU_SIGNED_DIV, a_in, b_in);
        pend_hi  = rr[63:32];
        pend_lo  = rr[31:0];
        acc_cyc  = cyc;
        vld_cyc  = cyc + latency(ctrl == ALU_SIGNED_DIV, a_in, b_in);
        busy_end = vld_cyc;
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (cyc <= busy_end && k < 100) begin @(posedge clk); #1; k++; end
    chk("idle_timeout", (k < 100) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic run_op(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b, output int at);
    @(posedge clk); #1;
    ctrl = c; a_in = a; b_in = b; start = 1'b1; at = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
  endtask

  initial begin
    int at, at2, nv0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    run_op(ALU_UNSIGNED_DIV, 32'd7, 32'd2, at);
    chk("divu_7_2_lo", lo, 32'd3);
    chk("divu_7_2_hi", hi, 32'd1);
    chk("divu_7_2_lat", last_vld - at, 32'd33);

    run_op(ALU_SIGNED_DIV, 32'hFFFF_FFF9, 32'd2, at);
    chk("div_m7_2_lo", lo, 32'hFFFF_FFFD);
    chk("div_m7_2_hi", hi, 32'hFFFF_FFFF);

    run_op(ALU_SIGNED_DIV, 32'd7, 32'hFFFF_FFFE, at);
    chk("div_7_m2_lo", lo, 32'hFFFF_FFFD);
    chk("div_7_m2_hi", hi, 32'd1);

    run_op(ALU_SIGNED_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, at);
    chk("div_m7_m2_lo", lo, 32'd3);
    chk("div_m7_m2_hi", hi, 32'hFFFF_FFFF);

    run_op(ALU_SIGNED_DIV, 32'h8000_0000, 32'hFFFF_FFFF, at);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'd0);

    run_op(ALU_UNSIGNED_DIV, 32'hFFFF_FFFF, 32'd3, at);
    chk("divu_max_lo", lo, 32'h5555_5555);
    chk("divu_max_hi", hi, 32'd0);

    run_op(ALU_UNSIGNED_DIV, 32'h1234, 32'd0, at);
    chk("divu_z_lo", lo, 32'hFFFF_FFFF);
    chk("divu_z_hi", hi, 32'h1234);
    run_op(ALU_SIGNED_DIV, 32'h1234, 32'd0, at);
    chk("div_z_lo", lo, 32'hFFFF_FFFF);
    chk("div_z_hi", hi, 32'h1234);
    run_op(ALU_SIGNED_DIV, 32'hFFFF_FFF9, 32'd0, at);
    chk("div_negz_lo", lo, 32'hFFFF_FFFF);
    chk("div_negz_hi", hi, 32'hFFFF_FFF9);

    // Flush ten cycles into an operation, then a fresh accept two cycles later
    nv0 = nvalid;
    @(posedge clk); #1;
    ctrl = ALU_SIGNED_DIV; a_in = 32'd1000; b_in = 32'd7; start = 1'b1; at = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_hold_lo", lo, 32'hFFFF_FFFF);
    chk("flush_hold_hi", hi, 32'hFFFF_FFF9);
    @(posedge clk); #1;
    ctrl = ALU_UNSIGNED_DIV; a_in = 32'd12; b_in = 32'd5; start = 1'b1; at2 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    chk("flush_restart_gap", at2 - at, 32'd12);
    chk("flush_12_5_lo", lo, 32'd2);
    chk("flush_12_5_hi", hi, 32'd2);
    chk("flush_12_5_lat", last_vld - at2, 32'd33);
    chk("flush_nvalid", nvalid - nv0, 32'd1);

    // start held through the busy window
    nv0 = nvalid;
    @(posedge clk); #1;
    ctrl = ALU_UNSIGNED_DIV; a_in = 32'd50; b_in = 32'd7; start = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    start = 1'b0;
    wait_idle();
    chk("held_nvalid", nvalid - nv0, 32'd1);
    chk("held_lo", lo, 32'd7);
    chk("held_hi", hi, 32'd1);

    // Non-divide op never accepted
    nv0 = nvalid;
    ctrl = ALU_ADD; a_in = 32'd3; b_in = 32'd4; start = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("add_nvalid", nvalid - nv0, 32'd0);

    run_op(ALU_UNSIGNED_DIV, 32'd5, 32'd9, at);
    chk("divu_5_9_lo", lo, 32'd0);
    chk("divu_5_9_hi", hi, 32'd5);
`ifdef DIV_EARLY_OUT_EN
    chk("divu_5_9_lat", last_vld - at, 32'd1);
`else
    chk("divu_5_9_lat", last_vld - at, 32'd33);
`endif

    // Reset in the middle of an operation
    @(posedge clk); #1;
    ctrl = ALU_UNSIGNED_DIV; a_in = 32'd99; b_in = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("midrst_lo", lo, 32'd0);
    resetn = 1'b1;
    repeat (40) begin @(posedge clk); #1; end
    chk("midrst_hi", hi, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
